vga_frame_checker: RTL and testbench

- Synthesizable, parametrised self-checking monitor for the VGA pixel stream.
- Over one frame, compares every pixel inside a configurable view window against an expected-pixel stream read from a show-ahead FIFO.
- Counts per-channel mismatches, records the first failing pixel and stops at a mismatch limit.
- Computes a CRC-16 signature of the window, so on-board runs can validate decoder output without a host.
- Sits beside the VGA unit in the top level; its results drive LEDs and seven-segment displays.

---
 rtl/vga_frame_checker_if.sv | 28 ++
 rtl/vga_frame_checker.sv | 179 +++++++++++++++++
 tb/tb_vga_frame_checker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_checker_if.sv
// Pixel stream from the VGA unit plus the show-ahead expected-pixel FIFO port.
// Latency: none, wiring only.
// Backpressure: none on the pixel side; Expected_req pops the FIFO head on the same edge.
interface vga_frame_checker_if #(
    parameter int NUM_CHANNELS = 3,
    parameter int COLOR_WIDTH  = 10
);
    logic                                  Vsync_n;
    logic                                  Pixel_valid;
    logic [9:0]                            Pixel_X;
    logic [9:0]                            Pixel_Y;
    logic [NUM_CHANNELS*COLOR_WIDTH-1:0]   Pixel_data;
    logic                                  Expected_valid;
    logic [NUM_CHANNELS*8-1:0]             Expected_data;
    logic                                  Expected_req;

    modport master (
        output Vsync_n, Pixel_valid, Pixel_X, Pixel_Y, Pixel_data,
        output Expected_valid, Expected_data,
        input  Expected_req
    );

    modport slave (
        input  Vsync_n, Pixel_valid, Pixel_X, Pixel_Y, Pixel_data,
        input  Expected_valid, Expected_data,
        output Expected_req
    );
endinterface

// File: rtl/vga_frame_checker.sv
// Compares one frame of window pixels against an expected stream; counts mismatches, records the first, signs the window with CRC-16.
// Latency: results visible the cycle after the strobe; Expected_req is combinational with the strobe.
// Backpressure: none; a missing FIFO word is recorded as an underrun and a single mismatch.
module vga_frame_checker #(
    parameter int VIEW_LEFT      = 160,
    parameter int VIEW_RIGHT     = 480,
    parameter int VIEW_TOP       = 120,
    parameter int VIEW_BOTTOM    = 360,
    parameter int NUM_CHANNELS   = 3,
    parameter int COLOR_WIDTH    = 10,
    parameter int MAX_MISMATCHES = 10,
    parameter int CNT_WIDTH      = 17
) (
    input  logic                     Clock_50,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic                     Clear,
    vga_frame_checker_if.slave       vif,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pass,
    output logic                     Halted,
    output logic                     Underrun,
    output logic [CNT_WIDTH-1:0]     Mismatch_count,
    output logic [CNT_WIDTH-1:0]     Checked_count,
    output logic [9:0]               First_x,
    output logic [9:0]               First_y,
    output logic [NUM_CHANNELS-1:0]  First_mask,
    output logic [15:0]              Signature
);
    localparam logic [9:0]           L_LEFT   = 10'(VIEW_LEFT);
    localparam logic [9:0]           L_RIGHT  = 10'(VIEW_RIGHT);
    localparam logic [9:0]           L_TOP    = 10'(VIEW_TOP);
    localparam logic [9:0]           L_BOTTOM = 10'(VIEW_BOTTOM);
    localparam logic [CNT_WIDTH-1:0] L_AREA   = CNT_WIDTH'((VIEW_RIGHT - VIEW_LEFT) * (VIEW_BOTTOM - VIEW_TOP));
    localparam logic [CNT_WIDTH-1:0] L_MAX    = CNT_WIDTH'(MAX_MISMATCHES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_LOW, S_SYNC, S_CHECK, S_DONE, S_HALT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_enable_d;
    logic                    r_vsync_d;
    logic                    r_underrun;
    logic [CNT_WIDTH-1:0]    r_mismatch;
    logic [CNT_WIDTH-1:0]    r_checked;
    logic [9:0]              r_first_x;
    logic [9:0]              r_first_y;
    logic [NUM_CHANNELS-1:0] r_first_mask;
    logic [15:0]             r_signature;

    logic                    w_vs_rise;
    logic                    w_vs_fall;
    logic                    w_hit;
    logic [NUM_CHANNELS-1:0] w_ch_mask;
    logic [NUM_CHANNELS-1:0] w_fail_mask;
    logic [CNT_WIDTH-1:0]    w_add;
    logic [CNT_WIDTH:0]      w_sum;
    logic [CNT_WIDTH-1:0]    w_mis_next;
    logic [15:0]             w_sig_next;

    // Folds the upper byte of every channel, red first, into the CRC one bit at a time.
    function automatic logic [15:0] crc_pixel(input logic [15:0] crc_in,
                                              input logic [NUM_CHANNELS*COLOR_WIDTH-1:0] pix);
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[15] ^ pix[ch*COLOR_WIDTH + COLOR_WIDTH - 8 + b];
                crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return crc;
    endfunction

    assign w_vs_rise = vif.Vsync_n & ~r_vsync_d;
    assign w_vs_fall = ~vif.Vsync_n & r_vsync_d;
    assign w_hit     = (r_state == S_CHECK) && vif.Pixel_valid
                    && (vif.Pixel_X >= L_LEFT) && (vif.Pixel_X < L_RIGHT)
                    && (vif.Pixel_Y >= L_TOP)  && (vif.Pixel_Y < L_BOTTOM);

    assign vif.Expected_req = w_hit && vif.Expected_valid;

    // Per-channel compare; the expected byte is left-aligned so any low display bit counts as a mismatch.
    always_comb begin
        w_ch_mask = '0;
        w_add     = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_ch_mask[c] = vif.Pixel_data[c*COLOR_WIDTH +: COLOR_WIDTH]
                        != (COLOR_WIDTH'(vif.Expected_data[c*8 +: 8]) << (COLOR_WIDTH - 8));
            w_add        = w_add + CNT_WIDTH'(w_ch_mask[c]);
        end
        if (!vif.Expected_valid) begin
            w_add = CNT_WIDTH'(1);
        end
        w_fail_mask = vif.Expected_valid ? w_ch_mask : '1;
        w_sum       = {1'b0, r_mismatch} + {1'b0, w_add};
        w_mis_next  = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
        w_sig_next  = crc_pixel(r_signature, vif.Pixel_data);
    end

    // State register plus edge-detect history for Enable and Vsync_n.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_enable_d <= 1'b0;
            r_vsync_d  <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_enable_d <= Enable;
            r_vsync_d  <= vif.Vsync_n;
        end
    end

    // Next state: arm on Enable edge, align to a full frame, halt takes priority over end-of-frame.
    always_comb begin
        w_next = r_state;
        if (Clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (Enable && !r_enable_d) w_next = S_WAIT_LOW;
                S_WAIT_LOW: if (!vif.Vsync_n)          w_next = S_SYNC;
                S_SYNC:     if (w_vs_rise)             w_next = S_CHECK;
                S_CHECK: begin
                    if (r_mismatch > L_MAX)            w_next = S_HALT;
                    else if (w_vs_fall)                w_next = S_DONE;
                end
                default:                               w_next = r_state;
            endcase
        end
    end

    // Result accumulation on every window hit; first-mismatch fields freeze once the count is non-zero.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_underrun   <= 1'b0;
            r_mismatch   <= '0;
            r_checked    <= '0;
            r_first_x    <= '0;
            r_first_y    <= '0;
            r_first_mask <= '0;
            r_signature  <= 16'hFFFF;
        end else if (Clear) begin
            r_underrun   <= 1'b0;
            r_mismatch   <= '0;
            r_checked    <= '0;
            r_first_x    <= '0;
            r_first_y    <= '0;
            r_first_mask <= '0;
            r_signature  <= 16'hFFFF;
        end else if (w_hit) begin
            r_checked   <= r_checked + CNT_WIDTH'(1);
            r_mismatch  <= w_mis_next;
            r_signature <= w_sig_next;
            if (!vif.Expected_valid) begin
                r_underrun <= 1'b1;
            end
            if ((r_mismatch == '0) && (w_fail_mask != '0)) begin
                r_first_x    <= vif.Pixel_X;
                r_first_y    <= vif.Pixel_Y;
                r_first_mask <= w_fail_mask;
            end
        end
    end

    assign Busy           = (r_state == S_SYNC) || (r_state == S_CHECK);
    assign Done           = (r_state == S_DONE) || (r_state == S_HALT);
    assign Halted         = (r_state == S_HALT);
    assign Pass           = Done && (r_mismatch == '0) && !r_underrun && (r_checked == L_AREA);
    assign Underrun       = r_underrun;
    assign Mismatch_count = r_mismatch;
    assign Checked_count  = r_checked;
    assign First_x        = r_first_x;
    assign First_y        = r_first_y;
    assign First_mask     = r_first_mask;
    assign Signature      = r_signature;
endmodule

// File: tb/tb_vga_frame_checker.sv
// Drives small random frames through the checker and compares every result against a frame-level model.
// Latency: checks sample registered outputs away from the clock edge.
// Backpressure: the bench FIFO pops only when the checker requests.
module tb_vga_frame_checker;
    localparam int FW = 16, FH = 10;
    localparam int VL = 4, VR = 12, VT = 3, VB = 8;
    localparam int AREA = (VR - VL) * (VB - VT);
    localparam int MAXM = 10;
    localparam int SAT  = (1 << 17) - 1;

    logic Clock_50 = 1'b0;
    logic Reset, Enable, Clear;
    logic Busy, Done, Pass, Halted, Underrun;
    logic [16:0] Mismatch_count, Checked_count;
    logic [9:0]  First_x, First_y;
    logic [2:0]  First_mask;
    logic [15:0] Signature;

    vga_frame_checker_if #(.NUM_CHANNELS(3), .COLOR_WIDTH(10)) vif ();

    vga_frame_checker #(
        .VIEW_LEFT(VL), .VIEW_RIGHT(VR), .VIEW_TOP(VT), .VIEW_BOTTOM(VB),
        .NUM_CHANNELS(3), .COLOR_WIDTH(10), .MAX_MISMATCHES(MAXM), .CNT_WIDTH(17)
    ) dut (
        .Clock_50(Clock_50), .Reset(Reset), .Enable(Enable), .Clear(Clear), .vif(vif),
        .Busy(Busy), .Done(Done), .Pass(Pass), .Halted(Halted), .Underrun(Underrun),
        .Mismatch_count(Mismatch_count), .Checked_count(Checked_count),
        .First_x(First_x), .First_y(First_y), .First_mask(First_mask), .Signature(Signature)
    );

    always #10 Clock_50 = ~Clock_50;

    int n_pass = 0, n_total = 0;
    int req_cnt, req_err;
    int ux = -1, uy = -1;
    logic [23:0] img  [FW*FH];
    logic [29:0] disp [FW*FH];
    logic [23:0] fifo [$];

    // Frame-level reference model.
    int m_checked, m_mis, m_fx, m_fy;
    bit m_under, m_armed, m_sync, m_check, m_done, m_halt;
    logic [2:0]  m_fm;
    logic [15:0] m_crc;

    function automatic logic [15:0] crc_bytes(input logic [15:0] c0, input logic [23:0] b);
        int crc = int'(c0);
        for (int i = 2; i >= 0; i--) begin
            crc = crc ^ (int'(b[i*8 +: 8]) << 8);
            for (int k = 0; k < 8; k++)
                crc = (crc & 32'h8000) != 0 ? ((crc << 1) ^ 32'h1021) & 32'hFFFF : (crc << 1) & 32'hFFFF;
        end
        return crc[15:0];
    endfunction

    function automatic bit in_win(input int x, input int y);
        return x >= VL && x < VR && y >= VT && y < VB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_checked = 0; m_mis = 0; m_fx = 0; m_fy = 0; m_fm = 3'b000; m_crc = 16'hFFFF;
        m_under = 0; m_armed = 0; m_sync = 0; m_check = 0; m_done = 0; m_halt = 0;
        req_cnt = 0; req_err = 0;
    endtask

    task automatic check_results(input string t);
        chk({t, "_busy"},     32'(Busy),           32'(m_sync || (m_check && !m_halt)));
        chk({t, "_done"},     32'(Done),           32'(m_done || m_halt));
        chk({t, "_halted"},   32'(Halted),         32'(m_halt));
        chk({t, "_pass"},     32'(Pass),           32'((m_done || m_halt) && m_mis == 0 && !m_under && m_checked == AREA));
        chk({t, "_underrun"}, 32'(Underrun),       32'(m_under));
        chk({t, "_mis"},      32'(Mismatch_count), m_mis);
        chk({t, "_checked"},  32'(Checked_count),  m_checked);
        chk({t, "_fx"},       32'(First_x),        m_fx);
        chk({t, "_fy"},       32'(First_y),        m_fy);
        chk({t, "_fmask"},    32'(First_mask),     32'(m_fm));
        chk({t, "_sig"},      32'(Signature),      32'(m_crc));
    endtask

    task automatic build(input bit all_wrong);
        for (int i = 0; i < FW*FH; i++) begin
            img[i] = 24'($urandom);
            if (in_win(i % FW, i / FW)) begin
                disp[i] = {img[i][23:16], 2'b00, img[i][15:8], 2'b00, img[i][7:0], 2'b00};
                if (all_wrong) disp[i] = disp[i] ^ {10'h1, 10'h1, 10'h1};
            end else begin
                disp[i] = 30'($urandom);
            end
        end
    endtask

    task automatic preload(input bit skip_first);
        fifo.delete();
        for (int y = VT; y < VB; y++)
            for (int x = VL; x < VR; x++)
                if (!(skip_first && x == VL && y == VT)) fifo.push_back(img[y*FW + x]);
    endtask

    task automatic pixel(input int x, input int y);
        bit hit, present;
        logic [29:0] pd;
        logic [23:0] ew;
        logic [2:0]  mask;
        logic        req;
        int          add;
        pd      = disp[y*FW + x];
        hit     = m_check && !m_halt && in_win(x, y);
        present = fifo.size() > 0 && !(x == ux && y == uy);
        ew      = fifo.size() > 0 ? fifo[0] : 24'($urandom);
        @(negedge Clock_50);
        vif.Pixel_valid = 1'b1; vif.Pixel_X = 10'(x); vif.Pixel_Y = 10'(y); vif.Pixel_data = pd;
        vif.Expected_valid = present; vif.Expected_data = ew;
        #2;
        req = vif.Expected_req;
        if (req !== (hit && present)) req_err++;
        if (req === 1'b1) req_cnt++;
        @(posedge Clock_50);
        if (req === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
        if (hit) begin
            m_checked++;
            mask = 3'b000; add = 0;
            if (!present) begin
                m_under = 1; add = 1; mask = 3'b111;
            end else begin
                for (int c = 0; c < 3; c++)
                    if (int'(pd[c*10 +: 10]) != int'(ew[c*8 +: 8]) * 4) begin mask[c] = 1'b1; add++; end
            end
            if (m_mis == 0 && add > 0) begin m_fx = x; m_fy = y; m_fm = mask; end
            m_mis = (m_mis + add > SAT) ? SAT : m_mis + add;
            m_crc = crc_bytes(m_crc, {pd[29:22], pd[19:12], pd[9:2]});
            if (m_mis > MAXM) m_halt = 1;
        end
        @(negedge Clock_50);
        vif.Pixel_valid = 1'b0;
        repeat ($urandom_range(1, 2) - 1) @(negedge Clock_50);
    endtask

    task automatic frame(input int stop_at);
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
                if (stop_at >= 0 && m_checked >= stop_at) return;
                pixel(x, y);
            end
    endtask

    task automatic vs_low();
        @(negedge Clock_50) vif.Vsync_n = 1'b0;
        if (m_check) begin m_check = 0; if (!m_halt) m_done = 1; end
        if (m_armed) begin m_armed = 0; m_sync = 1; end
        repeat (2) @(negedge Clock_50);
    endtask

    task automatic vs_high();
        @(negedge Clock_50) vif.Vsync_n = 1'b1;
        if (m_sync) begin m_sync = 0; m_check = 1; end
        repeat (2) @(negedge Clock_50);
    endtask

    task automatic arm();
        @(negedge Clock_50) Enable = 1'b1;
        m_armed = 1;
        @(negedge Clock_50) Enable = 1'b0;
    endtask

    task automatic clear();
        @(negedge Clock_50) Clear = 1'b1;
        @(negedge Clock_50) Clear = 1'b0;
        m_reset(); fifo.delete();
        #1 check_results("clr");
    endtask

    task automatic run_check();
        arm(); vs_low(); vs_high(); frame(-1); vs_low(); vs_high();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Enable = 1'b0; Clear = 1'b0;
        vif.Vsync_n = 1'b1; vif.Pixel_valid = 1'b0; vif.Pixel_X = '0; vif.Pixel_Y = '0;
        vif.Pixel_data = '0; vif.Expected_valid = 1'b0; vif.Expected_data = '0;
        m_reset();
        repeat (3) @(negedge Clock_50);
        #1 check_results("rst");
        chk("rst_req", 32'(vif.Expected_req), 0);
        @(negedge Clock_50) Reset = 1'b0;

        // Clean frame, armed mid-frame so the first frame is ignored.
        build(0); preload(0);
        arm(); vs_high(); frame(-1); vs_low();
        #1 check_results("t1_sync");
        vs_high(); frame(-1); vs_low(); vs_high();
        #1 check_results("t1");
        chk("t1_pass_abs", 32'(Pass), 1);
        chk("t1_pulses", req_cnt, AREA);
        chk("t1_req_err", req_err, 0);

        // Red off by 4 at one pixel, green and blue wrong at a later one.
        clear(); build(0);
        disp[4*FW + 5][29:20] = disp[4*FW + 5][29:20] + 10'd4;
        disp[6*FW + 8]        = disp[6*FW + 8] ^ {10'h0, 10'h1, 10'h1};
        preload(0); run_check();
        check_results("t2");
        chk("t2_mis_abs", 32'(Mismatch_count), 3);
        chk("t2_fmask_abs", 32'(First_mask), 3'b100);
        chk("t2_req_err", req_err, 0);

        // Every channel wrong: halt after the fourth window pixel.
        clear(); build(1); preload(0); run_check();
        check_results("t3");
        chk("t3_checked_abs", 32'(Checked_count), 4);
        chk("t3_halted_abs", 32'(Halted), 1);
        chk("t3_pulses", req_cnt, 4);
        chk("t3_req_err", req_err, 0);

        // Missing expected word at the first window pixel.
        clear(); build(0); preload(1); ux = VL; uy = VT; run_check(); ux = -1; uy = -1;
        check_results("t4");
        chk("t4_fmask_abs", 32'(First_mask), 3'b111);
        chk("t4_pulses", req_cnt, AREA - 1);
        chk("t4_req_err", req_err, 0);

        // Strobes just outside each window edge.
        clear(); build(0); preload(0);
        arm(); vs_low(); vs_high();
        pixel(VL - 1, VT); pixel(VR, VT); pixel(VL, VB); pixel(VL, VT - 1);
        #1 check_results("t5_mid");
        chk("t5_sig_abs", 32'(Signature), 16'hFFFF);
        chk("t5_pulses", req_cnt, 0);
        vs_low(); vs_high();
        #1 check_results("t5_end");

        // Asynchronous reset in the middle of a check, then a clean re-run.
        clear(); build(0); preload(0);
        arm(); vs_low(); vs_high(); frame(20);
        #1 check_results("t6_pre");
        #2 Reset = 1'b1;
        #1;
        m_reset();
        check_results("t6_rst");
        chk("t6_rst_req", 32'(vif.Expected_req), 0);
        @(negedge Clock_50) Reset = 1'b0;
        build(0); preload(0); run_check();
        check_results("t6");
        chk("t6_pass_abs", 32'(Pass), 1);
        chk("t6_req_err", req_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
